// File: rtl/board_move_controller_pkg.sv
// Shared types and constants for the 2048 board move sequencer.
// Latency: n/a (types, constants and the spawn LFSR step function only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        OP_SHIFT = 2'd0,
        OP_MERGE = 2'd1,
        OP_SPAWN = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        CS_INIT  = 3'd0,
        CS_IDLE  = 3'd1,
        CS_OPS   = 3'd2,
        CS_SPAWN = 3'd3,
        CS_CHECK = 3'd4,
        CS_DONE  = 3'd5
    } ctrl_state_t;

    localparam int NUM_LINES    = 4;
    localparam int OPS_PER_LINE = 3;
    localparam int NUM_CELLS    = 16;

    // Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10), shifting left.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/board_move_controller_if.sv
// Board-operation channel between the move sequencer (master) and the tile datapath (slave).
// Latency: n/a (wiring only); a transfer happens in any cycle with op_valid && op_ready.
// Backpressure: op_ready low holds every op_* field; dp_* status is returned by the slave.
// Signals: op_valid/op_ready handshake, op_code/op_dir/op_arg/op_val request fields,
//          dp_changed (per-transfer result), dp_has_2048/dp_has_empty/dp_can_merge (board status).
interface board_move_controller_if;
    import game_pkg::*;

    logic       op_valid;
    logic       op_ready;
    op_t        op_code;
    dir_t       op_dir;
    logic [3:0] op_arg;
    logic       op_val;
    logic       dp_changed;
    logic       dp_has_2048;
    logic       dp_has_empty;
    logic       dp_can_merge;

    modport master (
        output op_valid, op_code, op_dir, op_arg, op_val,
        input  op_ready, dp_changed, dp_has_2048, dp_has_empty, dp_can_merge
    );

    modport slave (
        input  op_valid, op_code, op_dir, op_arg, op_val,
        output op_ready, dp_changed, dp_has_2048, dp_has_empty, dp_can_merge
    );

endinterface

// File: rtl/board_move_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick spawn cells and tile values.
// Latency: new value every cycle; reset loads SEED asynchronously.
// Backpressure: none, it never stalls.
// Ports: clk, reset (async, active high), state (current 16-bit LFSR value).
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SEED;
        else       state <= lfsr_next(state);
    end

endmodule

// File: rtl/board_move_controller.sv
// Turns one direction press into 12 line ops (shift/merge/shift x4 lines), a spawn and a win/lose check.
// Latency: press sampled at T -> ops T+1..T+12, spawn T+13, check T+14, idle T+15 with no stalls.
// Backpressure: op_ready low holds all op_* fields and adds one cycle per stalled cycle.
// Ports: clk, reset, up/down/left/right levels, bus (master side of the op channel),
//        logic_win/logic_lose (sticky), busy, move_count.
module board_move_controller
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          COUNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up,
    input  logic                    down,
    input  logic                    left,
    input  logic                    right,
    board_move_controller_if.master bus,
    output logic                    logic_win,
    output logic                    logic_lose,
    output logic                    busy,
    output logic [COUNT_W-1:0]      move_count
);

    localparam logic [2:0] ST_INIT  = CS_INIT;
    localparam logic [2:0] ST_IDLE  = CS_IDLE;
    localparam logic [2:0] ST_OPS   = CS_OPS;
    localparam logic [2:0] ST_SPAWN = CS_SPAWN;
    localparam logic [2:0] ST_CHECK = CS_CHECK;
    localparam logic [2:0] ST_DONE  = CS_DONE;

    localparam logic [1:0] LAST_LINE = 2'(NUM_LINES - 1);
    localparam logic [1:0] LAST_STEP = 2'(OPS_PER_LINE - 1);
    localparam logic [3:0] LAST_TRY  = 4'(NUM_CELLS - 1);

    logic [2:0]  state;
    logic        armed;        // low during reset and the first cycle after it, so outputs stay 0
    logic [1:0]  init_left;
    logic [3:0]  prev_btn;
    dir_t        dir_q;
    logic [1:0]  line_q;
    logic [1:0]  step_q;
    logic        moved;
    logic        spawn_fresh;  // next spawn cycle is its first presentation: take cell/value from the LFSR
    logic        spawn_val;
    logic [3:0]  spawn_cell;
    logic [3:0]  attempt;
    logic [15:0] lfsr_state;
    logic        lfsr_unused;

    logic [3:0]  btn;
    logic [3:0]  edges;
    logic        spawning;
    logic        in_ops;
    logic        xfer;
    logic        spawn_done;
    logic        cur_val;
    logic [3:0]  cur_cell;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_state)
    );

    // Only the low 7 LFSR bits feed the spawn rules.
    assign lfsr_unused = ^lfsr_state[15:7];

    assign btn        = {up, down, left, right};
    assign edges      = btn & ~prev_btn;
    assign spawning   = (state == ST_INIT && armed) || state == ST_SPAWN;
    assign in_ops     = state == ST_OPS;
    assign xfer       = bus.op_valid && bus.op_ready;
    assign cur_cell   = spawn_fresh ? lfsr_state[3:0] : spawn_cell;
    assign cur_val    = spawn_fresh ? (lfsr_state[6:4] == 3'd0) : spawn_val;
    // A spawn ends when the cell took the tile, or after the 16th refused cell.
    assign spawn_done = spawning && xfer && (bus.dp_changed || attempt == LAST_TRY);

    assign bus.op_valid = spawning || in_ops;
    assign bus.op_dir   = dir_q;
    assign bus.op_arg   = spawning ? cur_cell : (in_ops ? {2'b00, line_q} : 4'd0);
    assign bus.op_val   = spawning && cur_val;
    assign busy         = spawning || in_ops || state == ST_CHECK;

    always_comb begin
        bus.op_code = OP_SHIFT;
        if (spawning)                     bus.op_code = OP_SPAWN;
        else if (in_ops && step_q == 2'd1) bus.op_code = OP_MERGE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_INIT;
            armed       <= 1'b0;
            init_left   <= 2'd2;
            prev_btn    <= 4'd0;
            dir_q       <= DIR_UP;
            line_q      <= 2'd0;
            step_q      <= 2'd0;
            moved       <= 1'b0;
            spawn_fresh <= 1'b1;
            spawn_val   <= 1'b0;
            spawn_cell  <= 4'd0;
            attempt     <= 4'd0;
            logic_win   <= 1'b0;
            logic_lose  <= 1'b0;
            move_count  <= '0;
        end else begin
            prev_btn <= btn;
            armed    <= 1'b1;

            // Spawn cell/value are frozen at first presentation; a refused cell moves to the next one.
            if (spawning) begin
                if (xfer) begin
                    if (spawn_done) begin
                        attempt     <= 4'd0;
                        spawn_fresh <= 1'b1;
                    end else begin
                        attempt     <= attempt + 4'd1;
                        spawn_fresh <= 1'b0;
                        spawn_cell  <= cur_cell + 4'd1;
                        spawn_val   <= cur_val;
                    end
                end else if (spawn_fresh) begin
                    spawn_fresh <= 1'b0;
                    spawn_cell  <= cur_cell;
                    spawn_val   <= cur_val;
                end
            end

            case (state)
                ST_INIT: begin
                    if (spawn_done) begin
                        init_left <= init_left - 2'd1;
                        if (init_left == 2'd1) state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|edges) begin
                        if (edges[3])      dir_q <= DIR_UP;
                        else if (edges[2]) dir_q <= DIR_DOWN;
                        else if (edges[1]) dir_q <= DIR_LEFT;
                        else               dir_q <= DIR_RIGHT;
                        line_q <= 2'd0;
                        step_q <= 2'd0;
                        moved  <= 1'b0;
                        state  <= ST_OPS;
                    end
                end
                ST_OPS: begin
                    if (xfer) begin
                        moved <= moved | bus.dp_changed;
                        if (step_q == LAST_STEP) begin
                            step_q <= 2'd0;
                            line_q <= line_q + 2'd1;
                            if (line_q == LAST_LINE)
                                state <= (moved | bus.dp_changed) ? ST_SPAWN : ST_IDLE;
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end
                end
                ST_SPAWN: begin
                    if (spawn_done) begin
                        move_count <= move_count + COUNT_W'(1);
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.dp_has_2048) begin
                        logic_win <= 1'b1;
                        state     <= ST_DONE;
                    end else if (!bus.dp_has_empty && !bus.dp_can_merge) begin
                        logic_lose <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
